// File: rtl/fetcher.sv
// Instruction-fetch front end.
// Issues one word read at a time to the memory controller and buffers
// returned words in a prefetch FIFO. Pops one instruction per cycle to the
// dispatcher unless stalled. A ROB redirect flushes the FIFO and re-steers
// the PC.
// Optional feature: define IF_JAL_PREDICT_EN to follow JAL targets at fetch.
//
// Handshake: IF_req is a level that rises with IF_addr and holds both stable
// until the single-cycle MC_done pulse returns MC_inst. flag_IF is a
// one-cycle valid for inst_IF/pc_IF with no back-pressure. stall_IF only
// suppresses the pop. Everything is sampled only when rdy=1.
// fsm_state exposes the fetch FSM: 0=IDLE, 1=WAIT, 2=DISCARD.
module fetcher #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        IF_req,
  output logic [31:0] IF_addr,
  input  logic        MC_done,
  input  logic [31:0] MC_inst,
  input  logic        stall_IF,
  input  logic        jump_flag,
  input  logic [31:0] jump_pc,
  output logic        flag_IF,
  output logic [31:0] inst_IF,
  output logic [31:0] pc_IF,
  output logic [1:0]  fsm_state
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [31:0]   pc;
  logic [31:0]   next_pc;
  logic [31:0]   fifo_pc   [QUEUE_DEPTH];
  logic [31:0]   fifo_inst [QUEUE_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic do_pop;
  logic do_push;
  logic do_issue;

  // Per-cycle decisions; a redirect suppresses pop, push and a new request.
  always_comb begin
    do_pop   = (count != '0) && !stall_IF && !jump_flag;
    do_push  = (state == WAIT) && MC_done && !jump_flag;
    do_issue = (state == IDLE) && !jump_flag &&
               ((count < CW'(QUEUE_DEPTH)) || do_pop);
  end

  // PC following the word returned now: sequential, or the JAL target.
  always_comb begin
    next_pc = pc + 32'd4;
`ifdef IF_JAL_PREDICT_EN
    if (MC_inst[6:0] == 7'b1101111) begin
      next_pc = pc + {{11{MC_inst[31]}}, MC_inst[31], MC_inst[19:12],
                      MC_inst[20], MC_inst[30:21], 1'b0};
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= next_state;
    end
  end

  // FSM next state; any MC_done ends the outstanding request.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (do_issue) next_state = WAIT;
      WAIT: begin
        if (MC_done)        next_state = IDLE;
        else if (jump_flag) next_state = DISCARD;
      end
      DISCARD: if (MC_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: the request is outstanding in every non-IDLE state.
  always_comb begin
    IF_req    = (state != IDLE);
    fsm_state = state;
  end

  // FIFO storage; written only on push, no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && rdy && do_push) begin
      fifo_pc[tail]   <= pc;
      fifo_inst[tail] <= MC_inst;
    end
  end

  // PC, pointers, request address and dispatcher output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      IF_addr <= 32'h0;
      flag_IF <= 1'b0;
      inst_IF <= 32'h0;
      pc_IF   <= 32'h0;
    end else if (rdy) begin
      if (do_issue) begin
        IF_addr <= pc;
      end
      if (jump_flag) begin
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        flag_IF <= 1'b0;
        pc      <= jump_pc;
      end else begin
        if (do_push) begin
          tail <= tail + AW'(1);
          pc   <= next_pc;
        end
        if (do_pop) begin
          flag_IF <= 1'b1;
          inst_IF <= fifo_inst[head];
          pc_IF   <= fifo_pc[head];
          head    <= head + AW'(1);
        end else begin
          flag_IF <= 1'b0;
        end
        unique case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: memory-controller model, randomized
// stall/rdy/redirect stimulus, and a scoreboard fed by a program-flow model.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        IF_req;
  logic [31:0] IF_addr;
  logic        MC_done;
  logic [31:0] MC_inst;
  logic        stall_IF;
  logic        jump_flag;
  logic [31:0] jump_pc;
  logic        flag_IF;
  logic [31:0] inst_IF;
  logic [31:0] pc_IF;
  logic [1:0]  fsm_state;

  fetcher dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .IF_req    (IF_req),
    .IF_addr   (IF_addr),
    .MC_done   (MC_done),
    .MC_inst   (MC_inst),
    .stall_IF  (stall_IF),
    .jump_flag (jump_flag),
    .jump_pc   (jump_pc),
    .flag_IF   (flag_IF),
    .inst_IF   (inst_IF),
    .pc_IF     (pc_IF),
    .fsm_state (fsm_state)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int delivered   = 0;
  bit mon_en      = 1'b0;

  // Expected dispatcher stream, each entry {pc, inst}.
  logic [63:0] exp_q[$];
  logic [31:0] gen_pc;

  // Memory-controller model state.
  bit          mc_busy;
  int          mc_cnt;
  logic [31:0] mc_addr;
  logic [31:0] req_log[$];

  // Program image: mostly ALU ops tagged with their address, a JAL (+0x40)
  // at every address that is 0x34 modulo 0x80.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[6:2] == 5'd13) return 32'h0400006F;
    return {a[21:2], 5'd1, 7'h13};
  endfunction

  // Architectural fetch order: where the fetch stream goes after pc.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w);
    logic [31:0] off;
    off = 32'd4;
`ifdef IF_JAL_PREDICT_EN
    if (w[6:0] == 7'b1101111) begin
      off = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    end
`endif
    return p + off;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({gen_pc, mem_word(gen_pc)});
      gen_pc = model_next(gen_pc, mem_word(gen_pc));
    end
  endtask

  // Driver task: one memory-controller step, called at each negedge while
  // rdy still holds the value seen at the preceding posedge.
  task automatic mc_step(input int lo, input int hi);
    if (MC_done) begin
      if (rdy) begin
        MC_done = 1'b0;
        mc_busy = 1'b0;
      end
    end else if (mc_busy) begin
      if (mc_cnt <= 1) begin
        MC_done = 1'b1;
        MC_inst = mem_word(mc_addr);
      end else begin
        mc_cnt--;
      end
    end else if (IF_req) begin
      mc_busy = 1'b1;
      mc_addr = IF_addr;
      mc_cnt  = int'($urandom_range(lo, hi));
      req_log.push_back(IF_addr);
    end
  endtask

  // Monitor: sample outputs just after each edge and score them.
  initial begin
    logic        prev_req;
    logic        prev_flag;
    logic [31:0] prev_addr;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    logic [63:0] e;
    prev_req = 1'b0; prev_flag = 1'b0;
    prev_addr = '0; prev_inst = '0; prev_pc = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (prev_req && IF_req) check("if_addr_stable", IF_addr, prev_addr);
        if (!rdy) begin
          check("hold_flag_IF", {31'd0, flag_IF}, {31'd0, prev_flag});
          check("hold_inst_IF", inst_IF, prev_inst);
          check("hold_pc_IF", pc_IF, prev_pc);
          check("hold_IF_req", {31'd0, IF_req}, {31'd0, prev_req});
        end else if (flag_IF) begin
          delivered++;
          if (exp_q.size() == 0) begin
            check("unexpected_flag_IF", pc_IF, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("pc_IF", pc_IF, e[63:32]);
            check("inst_IF", inst_IF, e[31:0]);
          end
        end
      end
      prev_req  = IF_req;
      prev_flag = flag_IF;
      prev_addr = IF_addr;
      prev_inst = inst_IF;
      prev_pc   = pc_IF;
    end
  end

  // Stimulus.
  initial begin
    int waited;
    rst = 1'b1; rdy = 1'b1; stall_IF = 1'b0; jump_flag = 1'b0;
    jump_pc = '0; MC_done = 1'b0; MC_inst = '0; mc_busy = 1'b0; mc_cnt = 0;
    mc_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_IF_req", {31'd0, IF_req}, 32'd0);
    check("rst_IF_addr", IF_addr, 32'd0);
    check("rst_flag_IF", {31'd0, flag_IF}, 32'd0);
    check("rst_inst_IF", inst_IF, 32'd0);
    check("rst_pc_IF", pc_IF, 32'd0);

    // Held stall: the FIFO fills with exactly QUEUE_DEPTH words.
    gen_pc = 32'h0;
    refill();
    stall_IF = 1'b1;
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (40) begin
      @(negedge clk);
      mc_step(2, 2);
    end
    check("stall_req_count", req_log.size(), 32'd4);
    check("stall_IF_req_low", {31'd0, IF_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (req_log.size() > i) check("stall_req_addr", req_log[i], 32'(i * 4));
    end

    // Release: fetching resumes at 0x10.
    stall_IF = 1'b0;
    waited = 0;
    while (req_log.size() < 5 && waited < 200) begin
      @(negedge clk);
      mc_step(2, 2);
      waited++;
    end
    if (req_log.size() < 5) check("resume_timeout", req_log.size(), 32'd5);
    else check("resume_addr", req_log[4], 32'h10);

    // Randomized stalls, rdy holds, redirects and memory latency.
    repeat (3000) begin
      @(negedge clk);
      mc_step(1, 4);
      rdy       = ($urandom_range(0, 9) != 0);
      stall_IF  = ($urandom_range(0, 9) < 3);
      jump_flag = 1'b0;
      if (rdy && $urandom_range(0, 49) == 0) begin
        jump_flag = 1'b1;
        jump_pc   = 32'($urandom_range(0, 255)) << 2;
        exp_q.delete();
        gen_pc = jump_pc;
      end
      refill();
    end

    // Drain with the pipe open.
    rdy = 1'b1; stall_IF = 1'b0; jump_flag = 1'b0;
    repeat (60) begin
      @(negedge clk);
      mc_step(1, 4);
      refill();
    end
    check("deliveries_made", {31'd0, (delivered > 100)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
